// File: rtl/seq_mult_accumulator.sv
// Signed product accumulator with valid/ready result handshake.
// Build option: define SEQ_MULT_ACC_SAT_EN to saturate on overflow instead of wrapping.
module seq_mult_accumulator #(
  parameter int N     = 32,
  parameter int ACC_W = 72,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic [2*N-1:0]     prod_in,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] nxt;
  logic [CNT_W-1:0]        count;
  logic                    ovf_hit;
  logic                    xfer;
  logic                    last;

  assign ext  = ACC_W'($signed(prod_in));
  assign sum  = acc + ext;
  assign xfer = prod_valid && prod_ready;
  assign last = xfer && (count == CNT_W'(1));

  // Same-sign addends with a differently signed result.
  assign ovf_hit = (acc[ACC_W-1] == ext[ACC_W-1])
                && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef SEQ_MULT_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  always_comb begin
    nxt = sum;
    if (ovf_hit)
      nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
  end
`else
  assign nxt = sum;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        if (last)
          state_nx = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = (state == ACCUM);
    out_valid  = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= '0;
      count    <= len;
      overflow <= 1'b0;
    end else if (state == ACCUM && xfer) begin
      acc   <= nxt;
      count <= count - CNT_W'(1);
      if (ovf_hit)
        overflow <= 1'b1;
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_seq_mult_accumulator.sv
// Scoreboard bench for seq_mult_accumulator, 72-bit and 64-bit instances.
// The reference model follows SEQ_MULT_ACC_SAT_EN when defined.
module tb_seq_mult_accumulator;

`ifdef SEQ_MULT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic        out_ready;

  logic        pr_a, ov_a, bz_a, of_a;
  logic [71:0] acc_a;
  logic        pr_b, ov_b, bz_b, of_b;
  logic [63:0] acc_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  int xfers = 0;

  typedef struct {
    logic signed [127:0] acc;
    logic                ovf;
  } exp_t;

  exp_t q72[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  seq_mult_accumulator #(.N(32), .ACC_W(72), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(pr_a),
    .acc_out(acc_a), .out_valid(ov_a), .out_ready(out_ready),
    .busy(bz_a), .overflow(of_a)
  );

  seq_mult_accumulator #(.N(32), .ACC_W(64), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(pr_b),
    .acc_out(acc_b), .out_valid(ov_b), .out_ready(out_ready),
    .busy(bz_b), .overflow(of_b)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
  endtask

  // Exact-integer sum, wrapped or clamped into w bits after each addition.
  function automatic exp_t model(input int w, input logic [63:0] ps[$]);
    exp_t r;
    logic signed [127:0] one, mx, mn, p, s, m;
    one = 128'sd1;
    m   = one <<< w;
    mx  = (one <<< (w - 1)) - one;
    mn  = -(one <<< (w - 1));
    r.acc = '0;
    r.ovf = 1'b0;
    foreach (ps[i]) begin
      p = $signed(ps[i]);
      s = r.acc + p;
      if (s > mx) begin
        r.ovf = 1'b1;
        s = SAT ? mx : s - m;
      end else if (s < mn) begin
        r.ovf = 1'b1;
        s = SAT ? mn : s + m;
      end
      r.acc = s;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk)
    if (!reset && prod_valid && pr_a)
      xfers <= xfers + 1;

  logic        hold_prev = 1'b0;
  logic [71:0] acc_prev = '0;

  always @(negedge clk) begin
    exp_t e;
    if (hold_prev && ov_a)
      chk("stable", {56'b0, acc_a}, {56'b0, acc_prev});
    hold_prev <= ov_a && !out_ready;
    acc_prev  <= acc_a;
    if (ov_a && out_ready) begin
      if (q72.size() == 0) begin
        chk("unexpected72", 128'd1, 128'd0);
      end else begin
        e = q72.pop_front();
        chk("acc72", {56'b0, acc_a}, {56'b0, e.acc[71:0]});
        chk("ovf72", {127'b0, of_a}, {127'b0, e.ovf});
      end
    end
    if (ov_b && out_ready) begin
      if (q64.size() == 0) begin
        chk("unexpected64", 128'd1, 128'd0);
      end else begin
        e = q64.pop_front();
        chk("acc64", {64'b0, acc_b}, {64'b0, e.acc[63:0]});
        chk("ovf64", {127'b0, of_b}, {127'b0, e.ovf});
      end
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_acc"}, {56'b0, acc_a}, 128'd0);
    chk({name, "_acc64"}, {64'b0, acc_b}, 128'd0);
    chk({name, "_flags"},
        {120'b0, pr_a, ov_a, bz_a, of_a, pr_b, ov_b, bz_b, of_b},
        128'd0);
  endtask

  task automatic run_acc(input int l, input logic [63:0] ps[$],
                         input int gap, input int hold, input bit st_done);
    int base;
    int b;
    base = xfers;
    start = 1'b1;
    len = 8'(l);
    step();
    start = 1'b0;
    chk("busy_start", {127'b0, bz_a}, 128'd1);
    q72.push_back(model(72, ps));
    q64.push_back(model(64, ps));
    if (l == 0)
      chk("len0_ready", {127'b0, pr_a}, 128'd0);
    foreach (ps[i]) begin
      repeat (gap) step();
      prod_valid = 1'b1;
      prod_in = ps[i];
      b = 0;
      while (!pr_a && b < 50) begin
        step();
        b++;
      end
      if (!pr_a)
        chk("ready_timeout", 128'd0, 128'd1);
      step();
      prod_valid = 1'b0;
      prod_in = '0;
    end
    chk("latency", {126'b0, ov_a, ov_b}, 128'd3);
    repeat (hold) begin
      start = st_done;
      step();
      chk("held_valid", {127'b0, ov_a}, 128'd1);
    end
    out_ready = 1'b1;
    start = st_done;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    chk("idle_after_hs", {126'b0, bz_a, bz_b}, 128'd0);
    chk("xfer_count", 128'(xfers - base), 128'(l));
  endtask

  initial begin
    logic [63:0] ps[$];
    int base;
    int b;
    reset = 1'b1;
    start = 1'b0;
    len = '0;
    prod_in = '0;
    prod_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk_idle("reset");
    reset = 1'b0;
    step();

    ps = '{64'd14, -64'sd21, -64'sd200};
    run_acc(3, ps, 0, 0, 1'b0);

    ps = {};
    run_acc(0, ps, 0, 1, 1'b0);

    ps = '{64'd4, -64'sd57};
    run_acc(2, ps, 3, 5, 1'b1);

    len = 8'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod_in = 64'd7;
    step();
    prod_in = 64'd20;
    step();
    prod_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("midreset");
    ps = '{64'd5};
    run_acc(1, ps, 0, 0, 1'b0);

    ps = '{64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000};
    run_acc(2, ps, 0, 1, 1'b0);

    ps = '{-64'sd4611686018427387904, -64'sd4611686018427387904,
           -64'sd4611686018427387904, 64'd3};
    run_acc(4, ps, 1, 0, 1'b0);

    base = xfers;
    len = 8'd255;
    start = 1'b1;
    step();
    start = 1'b0;
    prod_valid = 1'b1;
    prod_in = 64'd1;
    ps = {};
    repeat (255) ps.push_back(64'd1);
    q72.push_back(model(72, ps));
    q64.push_back(model(64, ps));
    b = 0;
    while (!ov_a && b < 600) begin
      step();
      b++;
    end
    if (!ov_a)
      chk("len255_timeout", 128'd0, 128'd1);
    repeat (3) step();
    chk("len255_xfers", 128'(xfers - base), 128'd255);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    prod_valid = 1'b0;

    for (int k = 0; k < 10; k++) begin
      int l;
      l = $urandom_range(0, 10);
      ps = {};
      for (int i = 0; i < l; i++) begin
        if ($urandom_range(0, 1) != 0)
          ps.push_back({$urandom, $urandom});
        else
          ps.push_back(64'($signed(16'($urandom))));
      end
      run_acc(l, ps, $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    b = 0;
    while ((q72.size() != 0 || q64.size() != 0) && b < 20) begin
      step();
      b++;
    end
    chk("drain", 128'(q72.size() + q64.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
